// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder: DIGIT bits of A+B+Cin per clock, carry held in a register
// between digits, valid/ready handshake on both sides.
module multicycle_adder #(
  parameter int WIDTH  = 16,
  parameter int DIGIT  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("multicycle_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, acc;

  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             c_dig, c_msb, last;
  logic [WIDTH-1:0] acc_next;

  // One digit of the ripple; c_msb is the carry into the top bit of this digit,
  // which on the last digit is the carry into the word MSB.
  always_comb begin
    a_dig    = a_q[int'(cnt)*DIGIT +: DIGIT];
    b_dig    = b_q[int'(cnt)*DIGIT +: DIGIT];
    {c_dig, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    c_msb    = s_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
    acc_next = acc;
    acc_next[int'(cnt)*DIGIT +: DIGIT] = s_dig;
    last     = (int'(cnt) == N - 1);
  end

  // Partial sums build up in acc so Sum holds the previous result until DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      Sum       <= '0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= A;
            b_q      <= B;
            carry_q  <= Cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          acc     <= acc_next;
          carry_q <= c_dig;
          if (last) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            Sum       <= acc_next;
            Carry     <= c_dig;
            Overflow  <= SIGNED ? (c_msb ^ c_dig) : c_dig;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: four instances (DIGIT=4 unsigned, DIGIT=4 signed,
// DIGIT=16, DIGIT=1) driven by directed vectors, corner sequences and random ops.
module tb_multicycle_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid [4];
  logic        in_ready [4];
  logic [15:0] A        [4];
  logic [15:0] B        [4];
  logic        Cin      [4];
  logic        out_valid[4];
  logic        out_ready[4];
  logic [15:0] Sum      [4];
  logic        Carry    [4];
  logic        Overflow [4];
  logic        busy     [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(16), .DIGIT(4),  .SIGNED(1'b0)) u_d4u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .A(A[0]), .B(B[0]), .Cin(Cin[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .Sum(Sum[0]), .Carry(Carry[0]), .Overflow(Overflow[0]), .busy(busy[0]));
  multicycle_adder #(.WIDTH(16), .DIGIT(4),  .SIGNED(1'b1)) u_d4s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .A(A[1]), .B(B[1]), .Cin(Cin[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .Sum(Sum[1]), .Carry(Carry[1]), .Overflow(Overflow[1]), .busy(busy[1]));
  multicycle_adder #(.WIDTH(16), .DIGIT(16), .SIGNED(1'b0)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .A(A[2]), .B(B[2]), .Cin(Cin[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .Sum(Sum[2]), .Carry(Carry[2]), .Overflow(Overflow[2]), .busy(busy[2]));
  multicycle_adder #(.WIDTH(16), .DIGIT(1),  .SIGNED(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .A(A[3]), .B(B[3]), .Cin(Cin[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .Sum(Sum[3]), .Carry(Carry[3]), .Overflow(Overflow[3]), .busy(busy[3]));

  function automatic int n_of(input int d);
    case (d)
      2:       return 1;
      3:       return 16;
      default: return 4;
    endcase
  endfunction

  // Reference: plain 17-bit addition; signed overflow when both operands share a
  // sign and the result sign differs.
  task automatic ref_add(input int d, input logic [15:0] a, b, input logic cin,
                         output logic [15:0] s, output logic c, o);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    s = t[15:0];
    c = t[16];
    o = (d == 1) ? ((a[15] == b[15]) && (s[15] != a[15])) : c;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Runs one transaction on instance d. Entered and left just after a negedge.
  task automatic run_op(input int d, input logic [15:0] a, b, input logic cin,
                        input int hold, input bit rnd,
                        output logic [15:0] s, output logic c, o, output int lat);
    int t;
    if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
    t = 0;
    while (!in_ready[d] && t < 50) begin @(negedge clk); t++; end
    chk("in_ready_before_op", in_ready[d], 1);
    in_valid[d] = 1'b1; A[d] = a; B[d] = b; Cin[d] = cin;
    @(negedge clk);
    in_valid[d] = 1'b0; A[d] = 16'($urandom); B[d] = 16'($urandom); Cin[d] = 1'($urandom);
    chk("busy_after_accept", busy[d], 1);
    chk("in_ready_after_accept", in_ready[d], 0);
    lat = 0;
    while (!out_valid[d] && lat < 40) begin
      if (rnd) out_ready[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    s = Sum[d]; c = Carry[d]; o = Overflow[d];
    out_ready[d] = 1'b0;
    if (hold > 0) begin
      in_valid[d] = 1'b1; A[d] = 16'hAAAA; B[d] = 16'h0000; Cin[d] = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        chk("bp_out_valid", out_valid[d], 1);
        chk("bp_sum_stable", Sum[d], s);
        chk("bp_in_ready", in_ready[d], 0);
      end
      in_valid[d] = 1'b0;
    end else if (rnd) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk("post_hs_out_valid", out_valid[d], 0);
    chk("post_hs_in_ready", in_ready[d], 1);
    chk("post_hs_busy", busy[d], 0);
    chk("post_hs_sum_kept", Sum[d], s);
  endtask

  typedef struct {
    int          d;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] s;
    logic        c, o;
  } vec_t;

  vec_t vt[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s, es;
    logic        c, o, ec, eo;
    int          lat;

    vt[0] = '{0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[2] = '{1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[4] = '{1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[5] = '{2, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[6] = '{3, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};

    for (int d = 0; d < 4; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; A[d] = '0; B[d] = '0; Cin[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("rst_in_ready", in_ready[d], 0);
      chk("rst_out_valid", out_valid[d], 0);
      chk("rst_sum", Sum[d], 0);
      chk("rst_carry_ovf_busy", {Carry[d], Overflow[d], busy[d]}, 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) chk("idle_in_ready", in_ready[d], 1);

    // Directed vectors, expected values fixed in the table.
    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].d, vt[i].a, vt[i].b, vt[i].cin, 0, 1'b0, s, c, o, lat);
      chk($sformatf("vec%0d_sum", i), s, vt[i].s);
      chk($sformatf("vec%0d_carry", i), c, vt[i].c);
      chk($sformatf("vec%0d_ovf", i), o, vt[i].o);
      chk($sformatf("vec%0d_latency", i), lat, n_of(vt[i].d));
    end

    // Backpressure: five cycles of out_ready=0 with in_valid/0xAAAA pending.
    run_op(0, 16'h1111, 16'h2222, 1'b0, 5, 1'b0, s, c, o, lat);
    chk("bp_sum", s, 16'h3333);
    chk("bp_latency", lat, 4);

    // Reset after two RUN cycles aborts the operation.
    in_valid[0] = 1'b1; A[0] = 16'h1234; B[0] = 16'h1111; Cin[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready[0], 0);
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_sum", Sum[0], 0);
    chk("midrst_carry_ovf_busy", {Carry[0], Overflow[0], busy[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", in_ready[0], 1);
    chk("postrst_out_valid", out_valid[0], 0);
    run_op(0, 16'h0100, 16'h00FF, 1'b1, 0, 1'b0, s, c, o, lat);
    chk("postrst_sum", s, 16'h0200);
    chk("postrst_carry", c, 0);

    // Random operations vs the reference model.
    for (int d = 1; d < 4; d++) begin
      for (int k = 0; k < ((d == 1) ? 200 : 1000); k++) begin
        logic [15:0] ra, rb;
        logic        rc;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        ref_add(d, ra, rb, rc, es, ec, eo);
        run_op(d, ra, rb, rc, 0, 1'b1, s, c, o, lat);
        chk($sformatf("rnd_d%0d_sum", d), s, es);
        chk($sformatf("rnd_d%0d_carry", d), c, ec);
        chk($sformatf("rnd_d%0d_ovf", d), o, eo);
        chk($sformatf("rnd_d%0d_latency", d), lat, n_of(d));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
